// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: finds the retirement of trig_order and of its
// successor across all RVFI channels, then strobes check for one cycle.
// chk_reset holds attached checkers in reset until sequencing begins.
module rvfi_check_sequencer #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_WAIT     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [63:0]          trig_order,
  output logic                 chk_reset,
  output logic                 trig,
  output logic [7:0]           trig_chan,
  output logic                 check,
  output logic [7:0]           next_chan,
  output logic                 done,
  output logic                 timeout,
  output logic                 order_dup
);

  typedef enum logic [2:0] {
    RST,
    WAIT_TRIG,
    WAIT_NEXT,
    CHECK,
    DONE,
    TIMEOUT
  } state_t;

  localparam int MAXV = (MAX_WAIT > RESET_CYCLES) ? MAX_WAIT : RESET_CYCLES;
  localparam int CW   = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  state_t          r_state;
  state_t          w_stateNext;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cntNext;
  logic [7:0]      r_nextChan;
  logic [7:0]      w_nextChanD;
  logic            r_orderDup;

  logic [63:0]     w_succOrder;
  logic [NRET-1:0] w_tmatch;
  logic [NRET-1:0] w_nmatch;
  logic            w_anyT;
  logic [7:0]      w_tChan;
  logic            w_anyN;
  logic [7:0]      w_nChan;
  logic            w_anyNLate;
  logic [7:0]      w_nLateChan;
  logic            w_dup;

  // Per-channel trigger/successor matches; the successor wraps modulo 2^64.
  always_comb begin
    w_succOrder = trig_order + 64'd1;
    w_tmatch    = '0;
    w_nmatch    = '0;
    for (int i = 0; i < NRET; i++) begin
      w_tmatch[i] = rvfi_valid[i] && (rvfi_order[64*i +: 64] == trig_order);
      w_nmatch[i] = rvfi_valid[i] && (rvfi_order[64*i +: 64] == w_succOrder);
    end
  end

  // Lowest-index winners; the "late" successor must sit above the trigger channel.
  always_comb begin
    w_anyT      = 1'b0;
    w_tChan     = 8'd0;
    w_anyN      = 1'b0;
    w_nChan     = 8'd0;
    w_anyNLate  = 1'b0;
    w_nLateChan = 8'd0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (w_tmatch[i]) begin
        w_anyT  = 1'b1;
        w_tChan = 8'(i);
      end
      if (w_nmatch[i]) begin
        w_anyN  = 1'b1;
        w_nChan = 8'(i);
      end
    end
    for (int i = NRET - 1; i >= 0; i--) begin
      if (w_nmatch[i] && (8'(i) > w_tChan)) begin
        w_anyNLate  = 1'b1;
        w_nLateChan = 8'(i);
      end
    end
  end

  // Detect two valid channels carrying the same order in one cycle.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      for (int j = i + 1; j < NRET; j++) begin
        if (rvfi_valid[i] && rvfi_valid[j] &&
            (rvfi_order[64*i +: 64] == rvfi_order[64*j +: 64])) begin
          w_dup = 1'b1;
        end
      end
    end
  end

  // Next-state, wait counter and successor-channel capture.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_nextChanD = r_nextChan;
    case (r_state)
      RST: begin
        if (r_cnt == RST_LAST) begin
          w_stateNext = WAIT_TRIG;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      WAIT_TRIG: begin
        if (w_anyT) begin
          if (w_anyNLate) begin
            w_nextChanD = w_nLateChan;
            w_stateNext = CHECK;
          end else begin
            w_stateNext = WAIT_NEXT;
            w_cntNext   = '0;
          end
        end else if (r_cnt == WAIT_LAST) begin
          w_stateNext = TIMEOUT;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      WAIT_NEXT: begin
        if (w_anyN) begin
          w_nextChanD = w_nChan;
          w_stateNext = CHECK;
        end else if (r_cnt == WAIT_LAST) begin
          w_stateNext = TIMEOUT;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      CHECK:   w_stateNext = DONE;
      DONE:    w_stateNext = DONE;
      TIMEOUT: w_stateNext = TIMEOUT;
      default: w_stateNext = RST;
    endcase
  end

  // State, counter and sticky flags with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RST;
      r_cnt      <= '0;
      r_nextChan <= 8'd0;
      r_orderDup <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_nextChan <= w_nextChanD;
      if ((r_state != RST) && w_dup) begin
        r_orderDup <= 1'b1;
      end
    end
  end

  assign chk_reset = reset || (r_state == RST);
  assign trig      = !reset && (r_state == WAIT_TRIG) && w_anyT;
  assign trig_chan = w_tChan;
  assign check     = (r_state == CHECK);
  assign next_chan = r_nextChan;
  assign done      = (r_state == DONE);
  assign timeout   = (r_state == TIMEOUT);
  assign order_dup = r_orderDup;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Self-checking bench for rvfi_check_sequencer (NRET=2, RESET_CYCLES=2,
// MAX_WAIT=4). Each driven cycle pushes its hand-derived expected outputs;
// a negedge monitor pops and compares them.
module tb_rvfi_check_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   rvfi_valid = '0;
  logic [127:0] rvfi_order = '0;
  logic [63:0]  trig_order = '0;
  logic         chk_reset;
  logic         trig;
  logic [7:0]   trig_chan;
  logic         check;
  logic [7:0]   next_chan;
  logic         done;
  logic         timeout;
  logic         order_dup;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       chkRst;
    logic       trig;
    logic [7:0] tChan;
    logic       check;
    logic [7:0] nextCh;
    logic       done;
    logic       timeout;
    logic       dup;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;

  rvfi_check_sequencer #(
    .NRET(2),
    .RESET_CYCLES(2),
    .MAX_WAIT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order),
    .trig_order(trig_order),
    .chk_reset(chk_reset),
    .trig(trig),
    .trig_chan(trig_chan),
    .check(check),
    .next_chan(next_chan),
    .done(done),
    .timeout(timeout),
    .order_dup(order_dup)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  function automatic exp_t mkExp(input string tag, input bit cr, input bit tr,
                                 input int tc, input bit ck, input int nc,
                                 input bit dn, input bit to, input bit dp);
    exp_t e;
    e.tag = tag; e.chkRst = cr; e.trig = tr; e.tChan = 8'(tc);
    e.check = ck; e.nextCh = 8'(nc); e.done = dn; e.timeout = to; e.dup = dp;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] v,
                               input logic [63:0] o0, input logic [63:0] o1,
                               input exp_t e);
    @(posedge clock);
    #1;
    reset      = rst;
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    expQ.push_back(e);
  endtask

  // Two reset cycles; the first is unchecked because state may be unknown.
  task automatic doReset(input logic [63:0] to, input string tag);
    @(posedge clock);
    #1;
    reset      = 1'b1;
    rvfi_valid = '0;
    trig_order = to;
    applyStimulus(1'b1, 2'b00, 64'd0, 64'd0, mkExp({tag, " reset"}, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Mid-cycle monitor: pop the expectation for the cycle and compare.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkOutput({cur.tag, " chk_reset"}, 64'(chk_reset), 64'(cur.chkRst));
      checkOutput({cur.tag, " trig"},      64'(trig),      64'(cur.trig));
      if (cur.trig) checkOutput({cur.tag, " trig_chan"}, 64'(trig_chan), 64'(cur.tChan));
      checkOutput({cur.tag, " check"},     64'(check),     64'(cur.check));
      checkOutput({cur.tag, " next_chan"}, 64'(next_chan), 64'(cur.nextCh));
      checkOutput({cur.tag, " done"},      64'(done),      64'(cur.done));
      checkOutput({cur.tag, " timeout"},   64'(timeout),   64'(cur.timeout));
      checkOutput({cur.tag, " order_dup"}, 64'(order_dup), 64'(cur.dup));
    end
  end

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // Single-channel sequence 3,4,5,6 with trig_order=5.
    doReset(64'd5, "t1");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t1 rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t1 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd3, 64'd0, mkExp("t1 o3", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd4, 64'd0, mkExp("t1 o4", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd5, 64'd0, mkExp("t1 o5", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd6, 64'd0, mkExp("t1 o6", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t1 chk", 0, 0, 0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t1 done", 0, 0, 0, 0, 0, 1, 0, 0));
    applyStimulus(0, 2'b01, 64'd5, 64'd0, mkExp("t1 retrig", 0, 0, 0, 0, 0, 1, 0, 0));

    // Trigger and successor in one cycle, successor on the higher channel.
    doReset(64'd10, "t2");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2 rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b11, 64'd10, 64'd11, mkExp("t2 pair", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2 chk", 0, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2 done", 0, 0, 0, 0, 1, 1, 0, 0));

    // Successor on a lower channel than the trigger does not count.
    doReset(64'd10, "t2b");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2b rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2b rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b11, 64'd11, 64'd10, mkExp("t2b swap", 0, 1, 1, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b10, 64'd0, 64'd11, mkExp("t2b next", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2b chk", 0, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t2b done", 0, 0, 0, 0, 1, 1, 0, 0));

    // Duplicate orders: ignored in RST, flagged afterwards, lowest channel wins.
    doReset(64'd10, "t3");
    applyStimulus(0, 2'b11, 64'd7, 64'd7, mkExp("t3 rstdup", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t3 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b11, 64'd10, 64'd10, mkExp("t3 dup", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t3 flag", 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 2'b01, 64'd11, 64'd0, mkExp("t3 next", 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t3 chk", 0, 0, 0, 1, 0, 0, 0, 1));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t3 done", 0, 0, 0, 0, 0, 1, 0, 1));

    // All-ones trigger; successor wraps to 0.
    doReset(ALL1, "t4");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t4 rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t4 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, ALL1, 64'd0, mkExp("t4 trig", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b10, 64'd0, 64'd0, mkExp("t4 wrap", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t4 chk", 0, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t4 done", 0, 0, 0, 0, 1, 1, 0, 0));

    // Timeout in WAIT_NEXT after 4 idle cycles; late successor ignored.
    doReset(64'd20, "t5");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5 rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd20, 64'd0, mkExp("t5 trig", 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5 idle", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5 tmo", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 2'b01, 64'd21, 64'd0, mkExp("t5 late", 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5 hold", 0, 0, 0, 0, 0, 0, 1, 0));

    // Timeout in WAIT_TRIG; a trigger afterwards is not reported.
    doReset(64'd40, "t5b");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5b rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5b rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t5b idle", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd40, 64'd0, mkExp("t5b tmo", 0, 0, 0, 0, 0, 0, 1, 0));

    // Reset pulse in WAIT_NEXT clears flags, then the sequence completes.
    doReset(64'd30, "t6");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 rst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 rst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b11, 64'd30, 64'd30, mkExp("t6 trig", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 wait", 0, 0, 0, 0, 0, 0, 0, 1));
    doReset(64'd30, "t6 pulse");
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 rrst0", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 rrst1", 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd30, 64'd0, mkExp("t6 retrig", 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b01, 64'd31, 64'd0, mkExp("t6 next", 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 chk", 0, 0, 0, 1, 0, 0, 0, 0));
    applyStimulus(0, 2'b00, 64'd0, 64'd0, mkExp("t6 done", 0, 0, 0, 0, 0, 1, 0, 0));

    @(posedge clock);
    @(posedge clock);
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
